// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the memory-mapped UART. For each queued byte it writes TDR,
// sets CTRL[0], then polls STAT[1] through the frame, so the core only ever pushes.
`timescale 1ns/1ps

`ifndef UART_MUX_CTRL
`define UART_MUX_CTRL 3'd0
`endif
`ifndef UART_MUX_STAT
`define UART_MUX_STAT 3'd1
`endif
`ifndef UART_MUX_TDR
`define UART_MUX_TDR 3'd2
`endif
`ifndef UART_MUX_RDR
`define UART_MUX_RDR 3'd3
`endif
`ifndef UART_MUX_BAUD
`define UART_MUX_BAUD 3'd4
`endif

module uart_tx_feeder #(
   parameter int DEPTH         = 16,
   parameter int START_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy,
   output logic                   err,
   output logic                   uart_we,
   output logic [2:0]             uart_reg_num,
   output logic [31:0]            uart_wd,
   input  logic [31:0]            uart_rd
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [PW-1:0] POLL_LAST = PW'(START_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WR_TDR, WR_CTRL, WAIT_START, WAIT_DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] poll_q, poll_d;
   logic          skip_q;
   logic          err_q, err_d;
   logic          we_q, we_d;
   logic [2:0]    reg_num_q, reg_num_d;
   logic [31:0]   wd_q, wd_d;
   logic          push_ok, pop;
   logic          unused_rd;

   assign push_ok   = push && (count_q != FULL_CNT);
   assign unused_rd = ^{uart_rd[31:2], uart_rd[0]};

   always_comb begin
      state_d = state_q;
      poll_d  = poll_q;
      err_d   = err_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = WR_TDR;
            end
         end
         WR_TDR:  state_d = WR_CTRL;
         WR_CTRL: begin
            state_d = WAIT_START;
            poll_d  = '0;
         end
         // skip_q marks the first cycle of a poll state, where uart_rd still holds the
         // answer to whatever register was addressed before STAT.
         WAIT_START: begin
            poll_d = poll_q + 1'b1;
            if (!skip_q && uart_rd[1]) begin
               state_d = WAIT_DONE;
            end else if (poll_q == POLL_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!skip_q && !uart_rd[1]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register-port values are decoded from the next state so the registered outputs line up with the state.
   always_comb begin
      we_d      = 1'b0;
      reg_num_d = `UART_MUX_STAT;
      wd_d      = '0;
      case (state_d)
         WR_TDR: begin
            we_d      = 1'b1;
            reg_num_d = `UART_MUX_TDR;
            wd_d      = {24'h0, fifo_mem[rd_ptr_q]};
         end
         WR_CTRL: begin
            we_d      = 1'b1;
            reg_num_d = `UART_MUX_CTRL;
            wd_d      = 32'h1;
         end
         default: ;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         poll_q    <= '0;
         skip_q    <= 1'b0;
         err_q     <= 1'b0;
         we_q      <= 1'b0;
         reg_num_q <= `UART_MUX_STAT;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         poll_q    <= poll_d;
         skip_q    <= (state_d != state_q);
         err_q     <= err_d;
         we_q      <= we_d;
         reg_num_q <= reg_num_d;
         wd_q      <= wd_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign count        = count_q;
   assign full         = (count_q == FULL_CNT);
   assign empty        = (count_q == '0);
   assign busy         = (state_q != IDLE);
   assign err          = err_q;
   assign uart_we      = we_q;
   assign uart_reg_num = reg_num_q;
   assign uart_wd      = wd_q;
endmodule
